axi4_ram_slave: RTL
===================

# axi4_ram_slave

AXI4 slave backed by on-chip synchronous RAM that terminates the command-to-AXI4 bridge's master port. Accepts single-outstanding INCR bursts of up to 256 beats on the write channels (AW/W/B) and read channels (AR/R), stores data word-addressed, and returns read data with `rlast`. Used as a DDR stand-in for bench and bring-up builds, and as a small scratch memory behind the UART bridge.

## Interface
- `A_WIDTH`, 26: AXI address width (word address, one unit = one `D_WIDTH` word).
- `D_WIDTH`, 16: data width.
- `MEM_AWIDTH`, 10: RAM depth = 2^MEM_AWIDTH words; only `addr[MEM_AWIDTH-1:0]` is used.

Ports:
- `rstn`  in  1  reset, asynchronous, active-low.
- `clk`  in  1  clock.
- `awvalid` in 1, `awready` out 1, `awaddr` in A_WIDTH, `awlen` in 8: write address; beats = awlen+1.
- `wvalid` in 1, `wready` out 1, `wlast` in 1, `wdata` in D_WIDTH: write data.
- `bvalid` out 1, `bready` in 1: write response (no bresp; always OKAY).
- `arvalid` in 1, `arready` out 1, `araddr` in A_WIDTH, `arlen` in 8: read address.
- `rvalid` out 1, `rready` in 1, `rlast` out 1, `rdata` out D_WIDTH: read data.
- `err`  out 1: sticky burst-length error flag (see Configuration).

## Operation
- States: IDLE, WRITE, WRESP, RFETCH, RDATA. Registers: `addr[MEM_AWIDTH-1:0]`, `len[7:0]`, `cnt[7:0]`.
- IDLE: `awready`=1; `arready` = !awvalid (write wins on a same-cycle request).
  - AW handshake: addr<=awaddr[MEM_AWIDTH-1:0], len<=awlen, cnt<=0, -> WRITE.
  - AR handshake: addr<=araddr[MEM_AWIDTH-1:0], len<=arlen, cnt<=0, -> RFETCH.
- WRITE: `wready`=1. Each wvalid beat writes mem[addr]<=wdata, addr<=addr+1, cnt<=cnt+1. On beat with cnt==len -> WRESP. Burst length is set by `awlen` only; `wlast` does not end the burst.
- WRESP: `bvalid`=1 until bready, then -> IDLE.
- RFETCH: RAM read of mem[addr] registered into `rdata`; `rlast` <= (cnt==len); -> RDATA.
- RDATA: `rvalid`=1, `rdata`/`rlast` held stable until rready. On handshake: if rlast -> IDLE, else addr<=addr+1, cnt<=cnt+1, -> RFETCH.
- Address increment wraps modulo 2^MEM_AWIDTH; upper address bits ignored, no error.
- RAM contents are not reset and are undefined after power-up; reset does not alter them.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, rdata=0, err=0; state IDLE. awready/arready rise the first clock after rstn deasserts.
- Reset mid-burst: immediate return to IDLE; partially written beats remain in RAM; no B/R completion issued.
- Write: AW handshake at cycle t; wready=1 from t+1; one beat per cycle; bvalid asserted the cycle after the last beat; IDLE the cycle after the B handshake.
- Read: AR handshake at t; first rvalid at t+2; with rready held high, one beat every 2 cycles; IDLE the cycle after the rlast handshake.
- awready, wready, bvalid, rvalid and rlast are decoded from registered state. arready has a combinational path from awvalid only.
- Write-then-read of the same address in back-to-back transactions returns the new data; no bypass needed because of the single outstanding transaction.

## Configuration
- `AXI_RAM_WLAST_CHECK_EN` defined: in WRITE, a beat with wlast != (cnt==len) sets `err`=1 (sticky until reset). Burst length still follows awlen.
- Not defined: wlast is ignored and `err` is tied 0.

## Test plan
- Write awaddr=0x10, awlen=3, data 0x1111/0x2222/0x3333/0x4444; then read araddr=0x10, arlen=3 -> rdata 0x1111..0x4444 in order, rlast only on beat 4, bvalid exactly one cycle after the 4th write beat.
- Read arlen=0 at 0x12 -> single beat 0x3333 with rlast=1, rvalid at t+2 after AR handshake.
- Read 4 beats with rready low for 5 cycles on each beat -> rdata/rlast held stable, no beat lost or duplicated.
- MEM_AWIDTH=10: write awaddr=0x3FE, awlen=3 with 0xA0..0xA3; read 0x3FE len 3 -> 0xA0,0xA1,0xA2,0xA3; read 0x000 -> 0xA2 (wrap).
- With AXI_RAM_WLAST_CHECK_EN: awlen=2 with wlast on beat 2 -> err=1 and B still after beat 3. Without the macro, same stimulus -> err=0.
- Assert rstn low during beat 2 of a 4-beat read -> rvalid=0 next edge; after release, a new write/read pair completes normally.

Source files
------------

// File: rtl/axi4_ram_slave.sv
// AXI4 slave over word-addressed on-chip RAM; single outstanding INCR burst per direction.
// Optional AXI_RAM_WLAST_CHECK_EN: flag wlast/awlen disagreement on the sticky err output.
module axi4_ram_slave #(
  parameter int unsigned A_WIDTH    = 26,
  parameter int unsigned D_WIDTH    = 16,
  parameter int unsigned MEM_AWIDTH = 10
) (
  input  logic               rstn,
  input  logic               clk,
  input  logic               awvalid,
  output logic               awready,
  input  logic [A_WIDTH-1:0] awaddr,
  input  logic [7:0]         awlen,
  input  logic               wvalid,
  output logic               wready,
  input  logic               wlast,
  input  logic [D_WIDTH-1:0] wdata,
  output logic               bvalid,
  input  logic               bready,
  input  logic               arvalid,
  output logic               arready,
  input  logic [A_WIDTH-1:0] araddr,
  input  logic [7:0]         arlen,
  output logic               rvalid,
  input  logic               rready,
  output logic               rlast,
  output logic [D_WIDTH-1:0] rdata,
  output logic               err
);

  localparam int unsigned MEM_DEPTH = 2 ** MEM_AWIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_RFETCH,
    S_RDATA
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [MEM_AWIDTH-1:0] addr;
  logic [7:0]            len;
  logic [7:0]            cnt;
  logic [D_WIDTH-1:0]    mem [MEM_DEPTH];

  logic aw_hs;
  logic ar_hs;
  logic w_hs;
  logic b_hs;
  logic r_hs;
  logic last_beat;

  // Write wins a same-cycle request, so arready backs off whenever awvalid is up.
  assign arready   = awready & ~awvalid;
  assign aw_hs     = awvalid & awready;
  assign ar_hs     = arvalid & arready;
  assign w_hs      = wvalid & wready;
  assign b_hs      = bvalid & bready;
  assign r_hs      = rvalid & rready;
  assign last_beat = (cnt == len);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (aw_hs)      next_state = S_WRITE;
        else if (ar_hs) next_state = S_RFETCH;
      end
      S_WRITE:  if (w_hs && last_beat) next_state = S_WRESP;
      S_WRESP:  if (b_hs) next_state = S_IDLE;
      S_RFETCH: next_state = S_RDATA;
      S_RDATA:  if (r_hs) next_state = rlast ? S_IDLE : S_RFETCH;
      default:  next_state = S_IDLE;
    endcase
  end

  // Channel strobes are registered copies of the next state so they stay low in reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      rvalid  <= 1'b0;
    end else begin
      awready <= (next_state == S_IDLE);
      wready  <= (next_state == S_WRITE);
      bvalid  <= (next_state == S_WRESP);
      rvalid  <= (next_state == S_RDATA);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr  <= '0;
      len   <= 8'd0;
      cnt   <= 8'd0;
      rdata <= '0;
      rlast <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (aw_hs) begin
            addr <= awaddr[MEM_AWIDTH-1:0];
            len  <= awlen;
            cnt  <= 8'd0;
          end else if (ar_hs) begin
            addr <= araddr[MEM_AWIDTH-1:0];
            len  <= arlen;
            cnt  <= 8'd0;
          end
        end
        S_WRITE: begin
          if (w_hs) begin
            addr <= MEM_AWIDTH'(addr + 1'b1);
            cnt  <= 8'(cnt + 8'd1);
          end
        end
        S_RFETCH: begin
          rdata <= mem[addr];
          rlast <= last_beat;
        end
        S_RDATA: begin
          if (r_hs) begin
            rlast <= 1'b0;
            if (!rlast) begin
              addr <= MEM_AWIDTH'(addr + 1'b1);
              cnt  <= 8'(cnt + 8'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // RAM array has no reset; contents survive rstn.
  always_ff @(posedge clk) begin
    if (w_hs) mem[addr] <= wdata;
  end

`ifdef AXI_RAM_WLAST_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           err_q <= 1'b0;
    else if (w_hs && (wlast != last_beat)) err_q <= 1'b1;
  end

  assign err = err_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, awaddr[A_WIDTH-1:MEM_AWIDTH], araddr[A_WIDTH-1:MEM_AWIDTH]};
`else
  assign err = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, wlast, awaddr[A_WIDTH-1:MEM_AWIDTH], araddr[A_WIDTH-1:MEM_AWIDTH]};
`endif

endmodule
